// File: rtl/vga_port_bridge_shadowed.sv
// PicoBlaze port bridge holding a shadow copy of the VGA pointer-unit registers,
// with immediate write-through or VSync-aligned deferred commit of dirty entries.
module vga_port_bridge_shadowed #(
    parameter int         ADDR_W      = 4,
    parameter int         DATA_W      = 8,
    parameter logic [7:0] BASE_PORT   = 8'd40,
    parameter logic [7:0] STATUS_PORT = 8'd2
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [7:0]        Port_ID,
    input  logic [7:0]        IN_DATA,
    input  logic              Read_Strobe,
    input  logic              Write_Strobe,
    output logic [7:0]        OUT_DATA,
    input  logic              VSync,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemData,
    output logic              Write
);
    localparam int                DEPTH      = 1 << ADDR_W;
    localparam logic [7:0]        PORT_ADDR  = BASE_PORT;
    localparam logic [7:0]        PORT_DATA  = BASE_PORT + 8'd1;
    localparam logic [7:0]        PORT_CTRL  = BASE_PORT + 8'd2;
    localparam logic [7:0]        PORT_FRAME = BASE_PORT + 8'd3;
    localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(DEPTH - 1);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W-1:0] addr_ptr_q;
    logic [DATA_W-1:0] shadow_q [DEPTH];
    logic [DATA_W-1:0] shadow_d [DEPTH];
    logic [DEPTH-1:0]  dirty_q;
    logic [DEPTH-1:0]  dirty_d;
    logic              mode_q;
    logic              autoinc_q;
    logic              pending_q;
    logic [7:0]        frame_cnt_q;
    logic              vs_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_data_q;
    logic              write_q;

    logic wr_addr, wr_data, wr_ctrl;
    logic vs_fall, busy, commit_req, start_scan;
    logic [7:0] rd_shadow;

    assign wr_addr    = Write_Strobe && (Port_ID == PORT_ADDR);
    assign wr_data    = Write_Strobe && (Port_ID == PORT_DATA);
    assign wr_ctrl    = Write_Strobe && (Port_ID == PORT_CTRL);
    assign vs_fall    = vs_q && !VSync;
    assign busy       = (state_q == SCAN);
    assign commit_req = wr_ctrl && IN_DATA[2] && mode_q;
    assign start_scan = vs_fall && pending_q && (state_q == IDLE);

    // Per-entry next state: a CPU write in deferred mode re-marks the entry
    // dirty even if the scan is clearing it on the same cycle.
    genvar gi;
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic cpu_hit, scan_hit;
        assign cpu_hit      = wr_data && (addr_ptr_q == ADDR_W'(gi));
        assign scan_hit     = busy && (idx_q == ADDR_W'(gi));
        assign shadow_d[gi] = cpu_hit ? IN_DATA[DATA_W-1:0] : shadow_q[gi];
        assign dirty_d[gi]  = (cpu_hit && mode_q) ? 1'b1 :
                              (scan_hit ? 1'b0 : dirty_q[gi]);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                shadow_q[i] <= '0;
            end
            dirty_q <= '0;
        end else begin
            shadow_q <= shadow_d;
            dirty_q  <= dirty_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            vs_q        <= VSync;
            frame_cnt_q <= '0;
            addr_ptr_q  <= '0;
            mode_q      <= 1'b0;
            autoinc_q   <= 1'b0;
            pending_q   <= 1'b0;
            state_q     <= IDLE;
            idx_q       <= '0;
            mem_addr_q  <= '1;
            mem_data_q  <= '0;
            write_q     <= 1'b0;
        end else begin
            vs_q    <= VSync;
            write_q <= 1'b0;

            if (vs_fall) begin
                frame_cnt_q <= frame_cnt_q + 8'd1;
            end

            if (wr_addr) begin
                addr_ptr_q <= IN_DATA[ADDR_W-1:0];
            end else if (wr_data && autoinc_q) begin
                addr_ptr_q <= addr_ptr_q + ADDR_W'(1);
            end

            // Mode stays frozen while a commit is queued or streaming, so a
            // scan never runs alongside immediate write-through.
            if (wr_ctrl) begin
                autoinc_q <= IN_DATA[1];
                if (!pending_q && !busy && !commit_req) begin
                    mode_q <= IN_DATA[0];
                end
            end

            if (commit_req) begin
                pending_q <= 1'b1;
            end else if (start_scan) begin
                pending_q <= 1'b0;
            end

            if (wr_data && !mode_q) begin
                mem_addr_q <= addr_ptr_q;
                mem_data_q <= IN_DATA[DATA_W-1:0];
                write_q    <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (start_scan) begin
                        state_q <= SCAN;
                        idx_q   <= '0;
                    end
                end
                SCAN: begin
                    if (dirty_q[idx_q]) begin
                        mem_addr_q <= idx_q;
                        mem_data_q <= shadow_q[idx_q];
                        write_q    <= 1'b1;
                    end
                    idx_q <= idx_q + ADDR_W'(1);
                    if (idx_q == LAST_IDX) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        rd_shadow                = '0;
        rd_shadow[DATA_W-1:0]    = shadow_q[addr_ptr_q];
        OUT_DATA                 = 8'h00;
        if (Read_Strobe) begin
            if (Port_ID == PORT_DATA) begin
                OUT_DATA = rd_shadow;
            end else if (Port_ID == PORT_FRAME) begin
                OUT_DATA = frame_cnt_q;
            end else if (Port_ID == STATUS_PORT) begin
                OUT_DATA = {4'b0000, mode_q, busy, pending_q, ~VSync};
            end
        end
    end

    assign MemAddr = mem_addr_q;
    assign MemData = mem_data_q;
    assign Write   = write_q;

endmodule

// File: tb/tb_vga_port_bridge_shadowed.sv
// Directed-vector bench for vga_port_bridge_shadowed: immediate writes, autoinc
// wrap, deferred commit timing, scan collision, mode lock, reset abort, frame count.
`timescale 1ns/1ps
module tb_vga_port_bridge_shadowed;
    localparam logic [7:0] P_ADDR  = 8'd40;
    localparam logic [7:0] P_DATA  = 8'd41;
    localparam logic [7:0] P_CTRL  = 8'd42;
    localparam logic [7:0] P_FRAME = 8'd43;
    localparam logic [7:0] P_STAT  = 8'd2;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] Port_ID;
    logic [7:0] IN_DATA;
    logic       Read_Strobe;
    logic       Write_Strobe;
    logic [7:0] OUT_DATA;
    logic       VSync;
    logic [3:0] MemAddr;
    logic [7:0] MemData;
    logic       Write;

    int n_cmp = 0;
    int n_bad = 0;

    logic       exp_w [0:20];
    logic [3:0] exp_a [0:20];
    logic [7:0] exp_d [0:20];

    vga_port_bridge_shadowed #(
        .ADDR_W(4), .DATA_W(8), .BASE_PORT(8'd40), .STATUS_PORT(8'd2)
    ) dut (
        .CLK(CLK), .RESET(RESET), .Port_ID(Port_ID), .IN_DATA(IN_DATA),
        .Read_Strobe(Read_Strobe), .Write_Strobe(Write_Strobe), .OUT_DATA(OUT_DATA),
        .VSync(VSync), .MemAddr(MemAddr), .MemData(MemData), .Write(Write)
    );

    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // All port tasks start and end just after a falling clock edge.
    task automatic port_wr(input logic [7:0] port, input logic [7:0] data);
        Port_ID      = port;
        IN_DATA      = data;
        Write_Strobe = 1'b1;
        @(negedge CLK);
        Write_Strobe = 1'b0;
    endtask

    task automatic port_rd(input logic [7:0] port, output logic [7:0] data);
        Port_ID     = port;
        Read_Strobe = 1'b1;
        #1;
        data        = OUT_DATA;
        Read_Strobe = 1'b0;
    endtask

    task automatic check_rd(input string tag, input logic [7:0] port, input logic [7:0] exp);
        logic [7:0] d;
        port_rd(port, d);
        check_val(tag, 32'(d), 32'(exp));
    endtask

    task automatic clear_exp();
        for (int i = 0; i <= 20; i++) begin
            exp_w[i] = 1'b0;
            exp_a[i] = 4'h0;
            exp_d[i] = 8'h00;
        end
    endtask

    // Drops VSync, then checks 21 cycles after the commit edge E (n = edges past E).
    // Optionally strobes one CPU write sampled at edge E+cpu_n+1.
    task automatic scan_frame(input int cpu_n, input logic [7:0] cpu_port, input logic [7:0] cpu_data);
        logic [7:0] st;
        logic       pend;
        VSync = 1'b0;
        @(negedge CLK);
        for (int n = 0; n <= 20; n++) begin
            if (n == cpu_n + 1) Write_Strobe = 1'b0;
            pend = (cpu_n >= 0) && (cpu_port == P_CTRL) && cpu_data[2] && (n > cpu_n);
            if (n == 0 || n == 15 || n == 16) begin
                port_rd(P_STAT, st);
                check_val($sformatf("status_n%0d", n), 32'(st),
                          32'({4'b0000, 1'b1, (n < 16), pend, 1'b1}));
            end
            check_val($sformatf("scan_write_n%0d", n), 32'(Write), 32'(exp_w[n]));
            if (exp_w[n]) begin
                check_val($sformatf("scan_addr_n%0d", n), 32'(MemAddr), 32'(exp_a[n]));
                check_val($sformatf("scan_data_n%0d", n), 32'(MemData), 32'(exp_d[n]));
            end
            if (n == cpu_n) begin
                Port_ID      = cpu_port;
                IN_DATA      = cpu_data;
                Write_Strobe = 1'b1;
            end
            @(negedge CLK);
        end
        VSync = 1'b1;
        @(negedge CLK);
    endtask

    initial begin
        RESET        = 1'b1;
        VSync        = 1'b1;
        Port_ID      = 8'h00;
        IN_DATA      = 8'h00;
        Read_Strobe  = 1'b0;
        Write_Strobe = 1'b0;
        clear_exp();
        repeat (3) @(negedge CLK);

        check_val("rst_write", 32'(Write), 32'(1'b0));
        check_val("rst_memaddr", 32'(MemAddr), 32'(4'hF));
        check_val("rst_memdata", 32'(MemData), 32'(8'h00));
        RESET = 1'b0;
        @(negedge CLK);
        check_rd("rst_status", P_STAT, 8'h00);
        check_rd("rst_frame", P_FRAME, 8'h00);
        check_rd("rst_shadow", P_DATA, 8'h00);

        // Immediate write-through
        port_wr(P_ADDR, 8'd5);
        port_wr(P_DATA, 8'hA7);
        check_val("imm_write", 32'(Write), 32'(1'b1));
        check_val("imm_addr", 32'(MemAddr), 32'(4'd5));
        check_val("imm_data", 32'(MemData), 32'(8'hA7));
        @(negedge CLK);
        check_val("imm_one_cycle", 32'(Write), 32'(1'b0));
        check_rd("imm_readback", P_DATA, 8'hA7);
        Port_ID = P_DATA;
        #1;
        check_val("idle_bus", 32'(OUT_DATA), 32'(8'h00));

        // Autoinc wrap with back-to-back strobes
        port_wr(P_CTRL, 8'h02);
        port_wr(P_ADDR, 8'd15);
        port_wr(P_DATA, 8'h11);
        port_wr(P_DATA, 8'h22);
        port_wr(P_DATA, 8'h33);
        check_val("ai_third_addr", 32'(MemAddr), 32'(4'd1));
        port_wr(P_CTRL, 8'h00);
        port_wr(P_DATA, 8'h44);
        check_val("ai_ptr_after_wrap", 32'(MemAddr), 32'(4'd2));
        port_wr(P_ADDR, 8'd15);
        check_rd("ai_rb15", P_DATA, 8'h11);
        port_wr(P_ADDR, 8'd0);
        check_rd("ai_rb0", P_DATA, 8'h22);
        port_wr(P_ADDR, 8'd1);
        check_rd("ai_rb1", P_DATA, 8'h33);

        // Deferred commit of entries 2 and 9
        port_wr(P_CTRL, 8'h01);
        port_wr(P_ADDR, 8'd2);
        port_wr(P_DATA, 8'hB2);
        check_val("def_no_imm_write", 32'(Write), 32'(1'b0));
        port_wr(P_ADDR, 8'd9);
        port_wr(P_DATA, 8'hB9);
        port_wr(P_CTRL, 8'h05);
        check_rd("def_pending", P_STAT, 8'h0A);
        repeat (3) begin
            @(negedge CLK);
            check_val("def_wait_no_write", 32'(Write), 32'(1'b0));
        end
        clear_exp();
        exp_w[3] = 1'b1;  exp_a[3] = 4'd2;  exp_d[3] = 8'hB2;
        exp_w[10] = 1'b1; exp_a[10] = 4'd9; exp_d[10] = 8'hB9;
        scan_frame(-1, 8'h00, 8'h00);

        // Collision: CPU rewrites entry 4 on the cycle the scan reaches it
        port_wr(P_ADDR, 8'd4);
        port_wr(P_DATA, 8'h40);
        port_wr(P_CTRL, 8'h05);
        clear_exp();
        exp_w[5] = 1'b1; exp_a[5] = 4'd4; exp_d[5] = 8'h40;
        scan_frame(4, P_DATA, 8'h4F);
        check_rd("col_readback", P_DATA, 8'h4F);

        // Entry 4 stayed dirty; commit requested mid-scan queues the next frame
        port_wr(P_CTRL, 8'h05);
        clear_exp();
        exp_w[5] = 1'b1; exp_a[5] = 4'd4; exp_d[5] = 8'h4F;
        scan_frame(8, P_CTRL, 8'h05);
        check_rd("pend_next_frame", P_STAT, 8'h0A);
        clear_exp();
        scan_frame(-1, 8'h00, 8'h00);

        // Mode lock while pending
        port_wr(P_CTRL, 8'h05);
        port_wr(P_CTRL, 8'h00);
        check_rd("mode_lock", P_STAT, 8'h0A);

        // Reset mid-scan, on the edge that would emit entry 2
        port_wr(P_ADDR, 8'd2);
        port_wr(P_DATA, 8'h5A);
        port_wr(P_ADDR, 8'd7);
        port_wr(P_DATA, 8'h77);
        VSync = 1'b0;
        repeat (3) @(negedge CLK);
        check_rd("busy_before_reset", P_STAT, 8'h0D);
        RESET = 1'b1;
        @(negedge CLK);
        check_val("rst_scan_write", 32'(Write), 32'(1'b0));
        check_val("rst_scan_memaddr", 32'(MemAddr), 32'(4'hF));
        check_rd("rst_scan_status", P_STAT, 8'h01);
        RESET = 1'b0;
        VSync = 1'b1;
        @(negedge CLK);
        port_wr(P_CTRL, 8'h01);
        port_wr(P_CTRL, 8'h05);
        clear_exp();
        scan_frame(-1, 8'h00, 8'h00);

        // Frame counter wrap
        check_rd("frame_1", P_FRAME, 8'd1);
        repeat (254) begin
            VSync = 1'b0;
            @(negedge CLK);
            VSync = 1'b1;
            @(negedge CLK);
        end
        check_rd("frame_255", P_FRAME, 8'hFF);
        repeat (2) begin
            VSync = 1'b0;
            @(negedge CLK);
            VSync = 1'b1;
            @(negedge CLK);
        end
        check_rd("frame_257_wrap", P_FRAME, 8'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
